// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: loader FSM state encoding and
// the default frame start marker used by the program loader.
package cpu_pkg;

   typedef enum logic [2:0] {
      LD_IDLE  = 3'd0,
      LD_LEN   = 3'd1,
      LD_INSTR = 3'd2,
      LD_ARG   = 3'd3,
      LD_CSUM  = 3'd4
   } ld_state_e;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/prog_loader.sv
// Program loader: parses a framed byte stream
// (SYNC, LEN, LEN x {INSTR, ARG}, CSUM) and writes instr/arg pairs
// into the instruction memory write port, holding the CPU in reset
// until a frame passes its checksum.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_data/valid/ready   byte stream in (ready is always 1)
//   mem_we/addr/instr/arg instruction memory write port
//   cpu_hold              OR'd into CPU pc/flag reset
//   done                  1-cycle pulse on a good checksum
//   err                   sticky checksum error
//   busy                  FSM is not in IDLE
module prog_loader
   import cpu_pkg::*;
#(
   parameter int                WIDTH         = 8,
   parameter logic [WIDTH-1:0]  SYNC_BYTE     = WIDTH'(SYNC_BYTE_DEF),
   parameter bit                HOLD_AT_RESET = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_instr,
   output logic [WIDTH-1:0] mem_arg,
   output logic             cpu_hold,
   output logic             done,
   output logic             err,
   output logic             busy
);

   ld_state_e        state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] index_q, index_d;
   logic [WIDTH-1:0] csum_q, csum_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] instr_q, instr_d;
   logic [WIDTH-1:0] arg_q, arg_d;
   logic             we_q, we_d;
   logic             hold_q, hold_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   // index never reaches 2^WIDTH-1 before the compare, so this
   // WIDTH-bit increment cannot wrap within a frame
   logic [WIDTH-1:0] index_inc;
   assign index_inc = index_q + WIDTH'(1);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      index_d = index_q;
      csum_d  = csum_q;
      addr_d  = addr_q;
      instr_d = instr_q;
      arg_d   = arg_q;
      we_d    = 1'b0;
      hold_d  = hold_q;
      done_d  = 1'b0;
      err_d   = err_q;
      if (in_valid) begin
         unique case (state_q)
            LD_IDLE: begin
               if (in_data == SYNC_BYTE) begin
                  state_d = LD_LEN;
                  hold_d  = 1'b1;
                  err_d   = 1'b0;
               end
            end
            LD_LEN: begin
               if (in_data == '0) begin
                  state_d = LD_IDLE;
               end else begin
                  count_d = in_data;
                  index_d = '0;
                  csum_d  = '0;
                  state_d = LD_INSTR;
               end
            end
            LD_INSTR: begin
               instr_d = in_data;
               csum_d  = csum_q + in_data;
               state_d = LD_ARG;
            end
            LD_ARG: begin
               arg_d   = in_data;
               addr_d  = index_q;
               we_d    = 1'b1;
               csum_d  = csum_q + in_data;
               index_d = index_inc;
               if (index_inc == count_q) begin
                  state_d = LD_CSUM;
               end else begin
                  state_d = LD_INSTR;
               end
            end
            LD_CSUM: begin
               state_d = LD_IDLE;
               if (in_data == csum_q) begin
                  done_d = 1'b1;
                  hold_d = 1'b0;
               end else begin
                  err_d  = 1'b1;
                  hold_d = 1'b1;
               end
            end
            default: state_d = LD_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= LD_IDLE;
         count_q <= '0;
         index_q <= '0;
         csum_q  <= '0;
         addr_q  <= '0;
         instr_q <= '0;
         arg_q   <= '0;
         we_q    <= 1'b0;
         hold_q  <= HOLD_AT_RESET;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         index_q <= index_d;
         csum_q  <= csum_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         arg_q   <= arg_d;
         we_q    <= we_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign in_ready  = 1'b1;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_instr = instr_q;
   assign mem_arg   = arg_q;
   assign cpu_hold  = hold_q;
   assign done      = done_q;
   assign err       = err_q;
   assign busy      = (state_q != LD_IDLE);

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of frames plus a
// hand-written mid-frame reset sequence, writes checked by scoreboard.
module tb_prog_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_instr;
   logic [7:0] mem_arg;
   logic       cpu_hold;
   logic       done;
   logic       err;
   logic       busy;

   prog_loader dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_instr (mem_instr),
      .mem_arg   (mem_arg),
      .cpu_hold  (cpu_hold),
      .done      (done),
      .err       (err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [7:0] addr;
      logic [7:0] instr;
      logic [7:0] arg;
   } wr_t;

   typedef struct {
      int           n;
      logic [127:0] bytes;
      int           gap;
      bit           exp_done;
      bit           exp_err;
      bit           exp_hold;
   } vec_t;

   wr_t  sb[$];
   vec_t tbl[6];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   bit   prev_we = 1'b0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   // write-port monitor and scoreboard
   always @(negedge clk) begin
      if (mem_we) begin
         wr_t w;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr %0h", mem_addr);
         end else begin
            w = sb.pop_front();
            if (mem_addr !== w.addr || mem_instr !== w.instr ||
                mem_arg !== w.arg || cyc != w.cyc) begin
               errors++;
               $display("FAIL write got a=%0h i=%0h g=%0h c=%0d want a=%0h i=%0h g=%0h c=%0d",
                        mem_addr, mem_instr, mem_arg, cyc,
                        w.addr, w.instr, w.arg, w.cyc);
            end
         end
      end
      if (mem_we && prev_we) begin
         checks++;
         errors++;
         $display("FAIL we_width got 2 cycles want 1");
      end
      prev_we = mem_we;
      if (done) begin
         done_cnt++;
         checks++;
         if (cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL hold_at_done got %0b want 0", cpu_hold);
         end
      end
   end

   function automatic vec_t mk(input int n, input logic [127:0] b,
                               input int g, input bit d, input bit e,
                               input bit h);
      vec_t v;
      v.n = n; v.bytes = b; v.gap = g;
      v.exp_done = d; v.exp_err = e; v.exp_hold = h;
      return v;
   endfunction

   function automatic logic [7:0] byte_at(input vec_t v, input int k);
      return v.bytes[127-8*k -: 8];
   endfunction

   task automatic run_entry(input vec_t v, input string name);
      int s;
      int len;
      s = -1;
      for (int k = 0; k < v.n; k++)
         if (s < 0 && byte_at(v, k) == 8'hA5) s = k;
      len = (s >= 0) ? int'(byte_at(v, s + 1)) : 0;
      done_cnt = 0;
      for (int k = 0; k < v.n; k++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = byte_at(v, k);
         if (s >= 0 && k >= s + 3 && ((k - s - 3) % 2) == 0 &&
             ((k - s - 3) / 2) < len) begin
            wr_t w;
            w.cyc   = cyc + 1;
            w.addr  = 8'((k - s - 3) / 2);
            w.instr = byte_at(v, k - 1);
            w.arg   = byte_at(v, k);
            sb.push_back(w);
         end
         for (int g = 0; g < v.gap; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'h5A;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk({name, "_sb_empty"}, sb.size(), 0);
      chk({name, "_done_cnt"}, done_cnt, v.exp_done);
      chk({name, "_err"}, err, v.exp_err);
      chk({name, "_hold"}, cpu_hold, v.exp_hold);
      chk({name, "_busy"}, busy, 0);
   endtask

   initial begin
      tbl[0] = mk(7, 128'hA5021003_20FF3200_00000000_00000000, 0, 1, 0, 0);
      tbl[1] = mk(7, 128'hA5021003_20FF3300_00000000_00000000, 0, 0, 1, 1);
      tbl[2] = mk(7, 128'hA5021003_20FF3200_00000000_00000000, 0, 1, 0, 0);
      tbl[3] = mk(4, 128'h007EA500_00000000_00000000_00000000, 0, 0, 0, 1);
      tbl[4] = mk(5, 128'hA501ABCD_78000000_00000000_00000000, 3, 1, 0, 0);
      tbl[5] = mk(9, 128'hA503A501_02030405_B4000000_00000000, 1, 1, 0, 0);

      rst = 1'b1;
      in_valid = 1'b0;
      in_data = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_hold", cpu_hold, 1);
      chk("rst_busy", busy, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_addr", mem_addr, 0);
      rst = 1'b0;

      foreach (tbl[i]) run_entry(tbl[i], $sformatf("vec%0d", i));

      // reset while waiting for an ARG byte; rst wins over in_valid
      @(negedge clk); in_valid = 1'b1; in_data = 8'hA5;
      @(negedge clk); in_data = 8'h02;
      @(negedge clk); in_data = 8'h11;
      @(negedge clk);
      chk("pre_rst_busy", busy, 1);
      rst = 1'b1; in_data = 8'h22;
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_we", mem_we, 0);
      chk("mid_rst_hold", cpu_hold, 1);
      chk("mid_rst_addr", mem_addr, 0);
      chk("mid_rst_err", err, 0);
      repeat (2) @(negedge clk);
      chk("mid_rst_we2", mem_we, 0);
      run_entry(tbl[0], "after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
